array_bit_serializer: RTL

- Parallel-to-serial counterpart of the array bit-collector, which gathers one bit per clock into an 8-bit output array at a wrapping index.
- Accepts one WIDTH-bit word per valid/ready handshake and emits it one bit per accepted cycle, index 0 first.
- Reports the current bit index and marks the final bit, so the collector end can rebuild the word at matching positions.
- Sits between a word-oriented producer and the bit-serial collector path, on the same single clock.

---
 rtl/array_bit_pkg.sv | 13 +
 rtl/bit_idx_counter.sv | 26 ++
 rtl/array_bit_serializer.sv | 79 +++++++
 3 files changed

// File: rtl/array_bit_pkg.sv
// Shared types and helpers for the array bit serializer / collector path.
//   DEFAULT_WIDTH : default word width (bits per word)
//   ser_state_t   : serializer FSM states
//   idx_width()   : index width for a given word width (min 1 bit)
package array_bit_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  function automatic int idx_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/bit_idx_counter.sv
// Wrap-at-MAX bit index counter, shared with the collector side.
//   i_clk, i_arst_n : clock, async active-low reset
//   i_inc           : advance index (wraps MAX -> 0)
//   i_clr           : force index to 0 (wins over i_inc)
//   o_idx           : current index
//   o_last          : o_idx == MAX
module bit_idx_counter #(
  parameter int MAX = 7,
  parameter int W   = 3
) (
  input  logic         i_clk,
  input  logic         i_arst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_idx,
  output logic         o_last
);
  assign o_last = (o_idx == W'(MAX));

  // Explicit wrap at MAX so non-power-of-2 word widths work.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n)  o_idx <= '0;
    else if (i_clr) o_idx <= '0;
    else if (i_inc) o_idx <= o_last ? '0 : o_idx + 1'b1;
  end
endmodule

// File: rtl/array_bit_serializer.sv
// Parallel-to-serial word serializer, LSB (index 0) first.
//   i_clk, i_arst_n   : clock, async active-low reset
//   i_en              : global enable, gates both handshakes
//   i_data/i_valid    : word input; o_ready accepts it
//   o_bit/o_valid     : serial bit output; i_ready accepts it
//   o_idx             : array index of the current bit
//   o_last            : current bit is index WIDTH-1
//   o_busy            : a word is being shifted out
module array_bit_serializer
  import array_bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                        i_clk,
  input  logic                        i_arst_n,
  input  logic                        i_en,
  input  logic [WIDTH-1:0]            i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic                        o_bit,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [idx_width(WIDTH)-1:0] o_idx,
  output logic                        o_last
  ,output logic                       o_busy
);
  localparam int IDX_W = idx_width(WIDTH);

  ser_state_t       state, nstate;
  logic [WIDTH-1:0] shreg;
  logic             cnt_last;
  logic             bit_xfer;
  logic             load;

  bit_idx_counter #(.MAX(WIDTH-1), .W(IDX_W)) u_idx (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_inc    (bit_xfer),
    .i_clr    (load),
    .o_idx    (o_idx),
    .o_last   (cnt_last)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state <= IDLE;
    else           state <= nstate;
  end

  // Next state: a load coinciding with the final bit keeps us in SHIFT
  // so consecutive words stream without a bubble.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (load) nstate = SHIFT;
      SHIFT:   if (bit_xfer && cnt_last && !load) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Outputs / handshakes. In SHIFT o_ready is combinational on i_ready
  // and i_en: a new word is taken only as the final bit leaves.
  always_comb begin
    o_busy   = (state == SHIFT);
    o_valid  = o_busy;
    o_last   = o_busy & cnt_last;
    o_bit    = o_busy & shreg[0];
    o_ready  = o_busy ? (i_en & i_ready & cnt_last) : i_en;
    bit_xfer = o_valid & i_ready & i_en;
    load     = i_valid & o_ready & i_en;
  end

  // Captured copy only; i_data is ignored while shifting.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n)     shreg <= '0;
    else if (load)     shreg <= i_data;
    else if (bit_xfer) shreg <= cnt_last ? '0 : (shreg >> 1);
  end
endmodule
